alu_op_sequencer: RTL and testbench

//  Initiator side of the ALU operand/flag interface: accepts one operation request via valid/ready,

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_op_sequencer.sv | 109 ++++++++++
 tb/tb_alu_op_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encoding and NZCV flag bit positions
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_MUL = 4'h2,
    OP_DIV = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_MOD = 4'h7,
    OP_SHL = 4'h8,
    OP_SHR = 4'h9
  } alu_op_t;
  localparam logic [3:0] OP_LAST = 4'h9;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one request to a combinational ALU, waits SETTLE+1 cycles, returns result+NZCV
//   req_*  : valid/ready request (a, b, op); req_ready high only while idle
//   alu_*  : registered operands/opcode to the ALU, result and n/z/c/v flags back
//   rsp_*  : valid/ready response (result, {N,Z,C,V}, err for illegal op or DIV/MOD by zero)
//   clr_sticky/sticky_flags : accumulated flags; op_count : completed responses (wraps)
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  input  logic             clr_sticky,
  output logic [3:0]       sticky_flags,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam int SW = $clog2(SETTLE + 1);
  state_t           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]       op_q, op_d, flags_q, flags_d, sticky_q, sticky_d, alu_flags;
  logic             err_q, err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             legal, accept, capture, done;
  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_n;
    alu_flags[FLAG_Z] = alu_z;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
    legal   = req_op <= OP_LAST;
    accept  = state_q == S_IDLE && req_valid;
    // cnt counts SETTLE down to 0, so the bus is held SETTLE+1 cycles before capture
    capture = state_q == S_WAIT && cnt_q == '0;
    done    = state_q == S_RESP && rsp_ready;
    state_d = accept ? (legal ? S_WAIT : S_RESP) :
              capture ? S_RESP :
              done ? S_IDLE : state_q;
    cnt_d   = accept ? SW'(SETTLE) :
              (state_q == S_WAIT && cnt_q != '0) ? cnt_q - SW'(1) : cnt_q;
    a_d     = accept && legal ? req_a : a_q;
    b_d     = accept && legal ? req_b : b_q;
    op_d    = accept && legal ? req_op : op_q;
    res_d   = capture ? alu_result : (accept && !legal) ? '0 : res_q;
    flags_d = capture ? alu_flags : (accept && !legal) ? '0 : flags_q;
    err_d   = capture ? ((op_q == OP_DIV || op_q == OP_MOD) && b_q == '0) :
              (accept && !legal) ? 1'b1 : err_q;
    // a capture in the same cycle as a clear leaves only the freshly captured flags
    sticky_d = capture ? (clr_sticky ? alu_flags : sticky_q | alu_flags) :
               clr_sticky ? '0 : sticky_q;
    op_count_d = done ? op_count_q + CNT_W'(1) : op_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
      sticky_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
    end
  end
  assign req_ready    = state_q == S_IDLE;
  assign rsp_valid    = state_q == S_RESP;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_opcode   = op_q;
  assign rsp_result   = res_q;
  assign rsp_flags    = flags_q;
  assign rsp_err      = err_q;
  assign sticky_flags = sticky_q;
  assign op_count     = op_count_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table, directed and random checks of alu_op_sequencer with a behavioural 4-bit ALU
module tb_alu_op_sequencer;
  localparam int WIDTH = 4, SETTLE = 1, CNT_W = 2;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err, clr_sticky = 0;
  logic [3:0] req_a = 0, req_b = 0, req_op = 0, alu_a, alu_b, alu_opcode, alu_result;
  logic [3:0] rsp_result, rsp_flags, sticky_flags;
  logic alu_n, alu_z, alu_c, alu_v;
  logic [CNT_W-1:0] op_count;
  logic [7:0] alu_out;
  int n_pass = 0, n_total = 0;
  int m_cnt = 0;
  logic [3:0] m_sticky = 0, m_a = 0, m_b = 0, m_op = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .clr_sticky(clr_sticky),
    .sticky_flags(sticky_flags), .op_count(op_count)
  );

  // Behavioural ALU: returns {result, N, Z, C, V}; C is carry for ADD, no-borrow for SUB
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    int ua, ub, sa, sb;
    logic [3:0] r;
    logic c, v;
    ua = a; ub = b;
    sa = ua > 7 ? ua - 16 : ua;
    sb = ub > 7 ? ub - 16 : ub;
    r = 0; c = 0; v = 0;
    case (op)
      4'h0: begin r = 4'(ua + ub); c = (ua + ub) > 15; v = (sa + sb > 7) || (sa + sb < -8); end
      4'h1: begin r = 4'(ua - ub); c = ua >= ub; v = (sa - sb > 7) || (sa - sb < -8); end
      4'h2: begin r = 4'(ua * ub); c = (ua * ub) > 15; v = c; end
      4'h3: if (ub == 0) v = 1; else r = 4'(ua / ub);
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: if (ub == 0) v = 1; else r = 4'(ua % ub);
      4'h8: r = 4'(ua << (ub % 4));
      4'h9: r = 4'(ua >> (ub % 4));
      default: r = 0;
    endcase
    return {r, r[3], r == 0, c, v};
  endfunction

  always_comb alu_out = alu_f(alu_a, alu_b, alu_opcode);
  assign {alu_result, alu_n, alu_z, alu_c, alu_v} = alu_out;

  // Expected response {result, flags, err} from the interface rules
  function automatic logic [8:0] model_rsp(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    logic [7:0] f;
    if (op > 4'h9) return {4'h0, 4'h0, 1'b1};
    f = alu_f(a, b, op);
    return {f, (op == 4'h3 || op == 4'h7) && b == 0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op, input int dly,
                        input logic [3:0] er, input logic [3:0] ef, input logic ee);
    int lat;
    bit legal;
    legal = op <= 4'h9;
    check("req_ready_idle", req_ready, 1);
    req_a = a; req_b = b; req_op = op; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    check("latency", lat, legal ? SETTLE + 1 : 0);
    for (int i = 0; i < dly; i++) begin
      check("rsp_hold", {rsp_result, rsp_flags, rsp_err}, {er, ef, ee});
      check("req_ready_busy", req_ready, 0);
      req_a = ~a; req_b = ~b; req_op = 4'h0; req_valid = 1;
      @(posedge clk); #1;
    end
    req_valid = 0;
    check("rsp", {rsp_result, rsp_flags, rsp_err}, {er, ef, ee});
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (legal) begin
      m_sticky |= ef; m_a = a; m_b = b; m_op = op;
    end
    check("rsp_valid_drop", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
    check("op_count", op_count, m_cnt);
    check("sticky", sticky_flags, m_sticky);
    check("alu_bus", {alu_a, alu_b, alu_opcode}, {m_a, m_b, m_op});
  endtask

  typedef struct {
    logic [3:0] a, b, op, er, ef;
    logic ee;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] e;
    logic [3:0] ra, rb, rop;
    int lat;
    tbl[0] = '{4'd7, 4'd1, 4'h0, 4'd8,  4'b1001, 1'b0};
    tbl[1] = '{4'd3, 4'd3, 4'h1, 4'd0,  4'b0110, 1'b0};
    tbl[2] = '{4'd5, 4'd0, 4'h3, 4'd0,  4'b0101, 1'b1};
    tbl[3] = '{4'd5, 4'd0, 4'h7, 4'd0,  4'b0101, 1'b1};
    tbl[4] = '{4'd9, 4'd2, 4'hC, 4'd0,  4'b0000, 1'b1};
    tbl[5] = '{4'd3, 4'd6, 4'h2, 4'd2,  4'b0011, 1'b0};
    tbl[6] = '{4'd12,4'd10,4'h4, 4'd8,  4'b1000, 1'b0};
    tbl[7] = '{4'd3, 4'd2, 4'h8, 4'd12, 4'b1000, 1'b0};
    tbl[8] = '{4'd5, 4'd5, 4'h6, 4'd0,  4'b0100, 1'b0};
    tbl[9] = '{4'd2, 4'd5, 4'h1, 4'd13, 4'b1000, 1'b0};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_alu_bus", {alu_a, alu_b, alu_opcode}, 0);
    check("reset_rsp", {rsp_result, rsp_flags, rsp_err}, 0);
    check("reset_sticky", sticky_flags, 0);
    check("reset_op_count", op_count, 0);
    foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].op, i % 4, tbl[i].er, tbl[i].ef, tbl[i].ee);
    // sticky accumulate and clear
    clr_sticky = 1; @(posedge clk); #1 clr_sticky = 0; m_sticky = 0;
    check("sticky_cleared", sticky_flags, 4'b0000);
    run_op(4'd7, 4'd1, 4'h0, 0, 4'd8, 4'b1001, 1'b0);
    run_op(4'd3, 4'd3, 4'h1, 0, 4'd0, 4'b0110, 1'b0);
    check("sticky_both", sticky_flags, 4'b1111);
    run_op(4'd1, 4'd2, 4'hF, 1, 4'd0, 4'b0000, 1'b1);
    check("sticky_illegal_untouched", sticky_flags, 4'b1111);
    check("opcode_illegal_untouched", alu_opcode, 4'h1);
    clr_sticky = 1; @(posedge clk); #1 clr_sticky = 0; m_sticky = 0;
    check("sticky_clr_again", sticky_flags, 4'b0000);
    // capture wins over a simultaneous clear
    run_op(4'd3, 4'd3, 4'h1, 0, 4'd0, 4'b0110, 1'b0);
    clr_sticky = 1;
    req_a = 4'd7; req_b = 4'd1; req_op = 4'h0; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1 lat++; end
    clr_sticky = 0;
    check("capture_wins_valid", rsp_valid, 1);
    check("capture_wins_sticky", sticky_flags, 4'b1001);
    rsp_ready = 1; @(posedge clk); #1 rsp_ready = 0;
    m_cnt = (m_cnt + 1) % (1 << CNT_W); m_sticky = 4'b1001; m_a = 4'd7; m_b = 4'd1; m_op = 4'h0;
    check("capture_wins_count", op_count, m_cnt);
    // reset while waiting on the ALU
    req_a = 4'd2; req_b = 4'd3; req_op = 4'h0; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    check("in_wait_no_rsp", rsp_valid, 0);
    rst = 1; @(posedge clk); #1 rst = 0;
    m_cnt = 0; m_sticky = 0; m_a = 0; m_b = 0; m_op = 0;
    check("rst_wait_req_ready", req_ready, 1);
    check("rst_wait_op_count", op_count, 0);
    check("rst_wait_sticky", sticky_flags, 0);
    check("rst_wait_alu_bus", {alu_a, alu_b, alu_opcode}, 0);
    for (int i = 0; i < 3; i++) begin
      check("rst_wait_no_rsp", rsp_valid, 0);
      @(posedge clk); #1;
    end
    // counter wraps after 2^CNT_W responses
    for (int i = 0; i < 4; i++) run_op(4'd1, 4'd1, 4'h0, 0, 4'd2, 4'b0000, 1'b0);
    check("op_count_wrapped", op_count, 0);
    // random traffic against the model
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rop = 4'($urandom_range(0, 15));
      if (i % 5 == 0) rb = 0;
      e = model_rsp(ra, rb, rop);
      run_op(ra, rb, rop, int'($urandom_range(0, 3)), e[8:5], e[4:1], e[0]);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
